// File: rtl/adc_seq.sv
// adc_seq: continuous multi-channel sequencer for a 12-bit serial ADC
// (16-clock frames, address on DIN bits 2..4, result on DOUT bits 4..15).
// Optional feature: define ADC_SEQ_AVG4_EN to report the average of every
// four samples per channel instead of every sample.
module adc_seq #(
    parameter int NCH     = 8,
    parameter int CLK_DIV = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           enable,
    input  logic [NCH-1:0] chan_mask,
    output logic [11:0]    data,
    output logic [2:0]     data_ch,
    output logic           data_valid,
    output logic           busy,
    output logic           CS_N,
    output logic           SADDR,
    output logic           SCLK,
    input  logic           SDAT
);

    // One counter serves the SCLK half-period and the STOP hold time.
    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(2 * CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, STOP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [2:0]    cur_ch;    // channel being converted in this frame
    logic [2:0]    addr_ch;   // channel addressed in this frame (converted next)
    logic [2:0]    nxt_ch;
    logic          keep;      // this frame's result is reportable
    logic [11:0]   shreg;
    logic          rpt_pend;
    logic [11:0]   rpt_data;
    logic [2:0]    rpt_ch;

    // DIN carries the next channel address MSB first on bits 2, 3 and 4.
    function automatic logic addr_bit(input logic [3:0] idx, input logic [2:0] ch);
        case (idx)
            4'd2:    return ch[2];
            4'd3:    return ch[1];
            4'd4:    return ch[0];
            default: return 1'b0;
        endcase
    endfunction

    // Next channel: lowest set mask bit above cur_ch, else wrap to lowest set bit.
    always_comb begin
        // NOTE: a default before any conditional assignment keeps this block
        // purely combinational; a missing path would infer a latch.
        nxt_ch = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (chan_mask[i]) nxt_ch = 3'(i);
        end
        for (int i = NCH - 1; i >= 0; i--) begin
            if (chan_mask[i] && (i > int'(cur_ch))) nxt_ch = 3'(i);
        end
    end

    // Frame sequencer: drives CS_N/SCLK/SADDR and captures DOUT.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            CS_N     <= 1'b1;
            SCLK     <= 1'b1;
            SADDR    <= 1'b0;
            busy     <= 1'b0;
            cur_ch   <= '0;
            addr_ch  <= '0;
            keep     <= 1'b0;
            shreg    <= '0;
            rpt_pend <= 1'b0;
            rpt_data <= '0;
            rpt_ch   <= '0;
        end else begin
            rpt_pend <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (enable && |chan_mask) begin
                        state  <= SETUP;
                        CS_N   <= 1'b0;
                        busy   <= 1'b1;
                        cur_ch <= '0;   // converter powers up on channel 0
                    end
                end
                SETUP: begin
                    if (cnt == HALF_LAST) begin
                        state   <= SHIFT;
                        cnt     <= '0;
                        SCLK    <= 1'b0;
                        bit_idx <= '0;
                        SADDR   <= 1'b0;
                        addr_ch <= nxt_ch;
                        keep    <= chan_mask[0];  // first frame is always channel 0
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt != HALF_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (!SCLK) begin
                            SCLK <= 1'b1;
                            if (bit_idx >= 4'd4) shreg <= {shreg[10:0], SDAT};
                            if (bit_idx == 4'd15) begin
                                rpt_pend <= keep;
                                rpt_data <= {shreg[10:0], SDAT};
                                rpt_ch   <= cur_ch;
                                cur_ch   <= addr_ch;
                            end
                        end else if (bit_idx != 4'd15) begin
                            SCLK    <= 1'b0;
                            bit_idx <= bit_idx + 4'd1;
                            SADDR   <= addr_bit(bit_idx + 4'd1, addr_ch);
                        end else if (enable && |chan_mask) begin
                            SCLK    <= 1'b0;
                            bit_idx <= '0;
                            SADDR   <= 1'b0;
                            addr_ch <= nxt_ch;
                            keep    <= 1'b1;
                        end else begin
                            state <= STOP;
                            CS_N  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                STOP: begin
                    if (cnt == STOP_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADC_SEQ_AVG4_EN
    logic [13:0] acc  [NCH];
    logic [1:0]  acnt [NCH];
    logic [13:0] sum;

    assign sum = acc[rpt_ch] + 14'(rpt_data);

    // Result stage: accumulate four samples per channel, report the truncated mean.
    always_ff @(posedge clock) begin
        if (reset) begin
            data       <= '0;
            data_ch    <= '0;
            data_valid <= 1'b0;
            // NOTE: the accumulators are a handful of flops, not a RAM, and a
            // stale partial sum must never leak into a report, so they are reset.
            for (int i = 0; i < NCH; i++) begin
                acc[i]  <= '0;
                acnt[i] <= '0;
            end
        end else begin
            data_valid <= 1'b0;
            if (state == IDLE) begin
                for (int i = 0; i < NCH; i++) begin
                    acc[i]  <= '0;
                    acnt[i] <= '0;
                end
            end else if (rpt_pend) begin
                if (acnt[rpt_ch] == 2'd3) begin
                    data_valid    <= 1'b1;
                    data          <= sum[13:2];
                    data_ch       <= rpt_ch;
                    acc[rpt_ch]   <= '0;
                    acnt[rpt_ch]  <= '0;
                end else begin
                    acc[rpt_ch]  <= sum;
                    acnt[rpt_ch] <= acnt[rpt_ch] + 2'd1;
                end
            end
        end
    end
`else
    // Result stage: publish every reportable frame one clock after its last bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            data       <= '0;
            data_ch    <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= rpt_pend;
            if (rpt_pend) begin
                data    <= rpt_data;
                data_ch <= rpt_ch;
            end
        end
    end
`endif

endmodule

// File: doc/adc_seq.md
ADC_SEQ -- requirements
Module: adc_seq

Interface
REQ-001 SHALL have parameter NCH, default 8, number of sequenced analogue channels (1..8).
REQ-002 SHALL have parameter CLK_DIV, default 4, SCLK half-period in clock cycles (>=1).
REQ-003 SHALL have port clock  in  1  system clock; all logic on rising edge; one clock domain.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  in  1  run continuous conversion sequence while high.
REQ-006 SHALL have port chan_mask  in  NCH  bit i set = channel i included in sequence.
REQ-007 SHALL have port data  out  12  latest result, MSB first from converter.
REQ-008 SHALL have port data_ch  out  3  channel number of data.
REQ-009 SHALL have port data_valid  out  1  one-clock pulse, data/data_ch new.
REQ-010 SHALL have port busy  out  1  high while CS_N low.
REQ-011 SHALL have port CS_N  out  1  converter chip select, active low.
REQ-012 SHALL have port SADDR  out  1  converter address serial input (DIN).
REQ-013 SHALL have port SCLK  out  1  converter serial clock, registered, idle high.
REQ-014 SHALL have port SDAT  in  1  converter serial data output (DOUT).

Function
REQ-015 SHALL implement states IDLE, SETUP, SHIFT, STOP.
REQ-016 IDLE -> SETUP when enable=1 and chan_mask!=0; CS_N falls on entry to SETUP.
REQ-017 SETUP SHALL last CLK_DIV clocks with SCLK high, then -> SHIFT.
REQ-018 A frame SHALL be 16 SCLK periods, bit index 0..15; each period SCLK low CLK_DIV clocks then high CLK_DIV clocks.
REQ-019 SADDR SHALL change only as SCLK falls; bits 2,3,4 carry next channel address MSB first; all other bits 0.
REQ-020 SDAT SHALL be sampled on the clock SCLK rises, bits 4..15 -> data bits 11..0.
REQ-021 Address sent in frame k SHALL select conversion reported in frame k+1; first frame after CS_N falls SHALL convert channel 0.
REQ-022 Next channel SHALL be lowest set mask bit above current channel, wrapping to lowest set bit; mask sampled at start of each frame.
REQ-023 First-frame result SHALL be reported only if chan_mask[0]=1, else discarded.
REQ-024 data_valid SHALL pulse exactly one clock, the clock after bit-15 SDAT sample; data/data_ch update same clock and hold until next pulse.
REQ-025 At end of frame: enable=1 and mask!=0 -> next frame back-to-back, CS_N stays low; else -> STOP.
REQ-026 STOP SHALL hold SCLK high, CS_N high for 2*CLK_DIV clocks, then -> IDLE; busy=0 in IDLE and STOP.
REQ-027 enable falling mid-frame SHALL NOT abort; current frame completes and reports.
REQ-028 chan_mask change mid-frame SHALL take effect from next frame's address only.

Reset
REQ-029 reset=1 SHALL, on next clock, force IDLE, CS_N=1, SCLK=1, SADDR=0, data=0, data_ch=0, data_valid=0, busy=0, sequence pointer=0.
REQ-030 reset mid-frame SHALL abort immediately; partial result SHALL NOT be reported.
REQ-031 reset SHALL dominate enable on the same clock.

Configuration
REQ-032 Macro ADC_SEQ_AVG4_EN SHALL select per-channel averaging.
REQ-033 With ADC_SEQ_AVG4_EN: per-channel 14-bit accumulator and 2-bit count; data_valid only on 4th sample of a channel, data = sum[13:2] (truncate); accumulator/count cleared after report, on reset, and on entering IDLE.
REQ-034 Without ADC_SEQ_AVG4_EN: no accumulators; every frame result reported per REQ-024.

Verification
REQ-035 CLK_DIV=4, mask=8'h01, SDAT model returns 12'hABC -> data=12'hABC, data_ch=0, pulses every 128 clocks, CS_N low continuously.
REQ-036 mask=8'b1010_0100 -> SADDR addresses 2,5,7,2...; data_ch sequence 2,5,7,2; first-frame ch0 result discarded.
REQ-037 enable dropped at bit 6 -> frame completes, one data_valid, CS_N high 8 clocks, busy=0, IDLE.
REQ-038 reset asserted at bit 10 -> next clock CS_N=1, SCLK=1, no data_valid, data=0.
REQ-039 mask=0 with enable=1 -> CS_N stays high, no SCLK edges, busy=0.
REQ-040 ADC_SEQ_AVG4_EN, mask=8'h01, samples 100,101,102,104 -> single pulse, data=101 after 4th frame.
